// File: rtl/sort_mem_if.sv
// Read (AR/R) and write (AW/W/B) handshake channels between the sort controller
// and its word-addressed memory.
interface sort_mem_if #(
   parameter int ADDR_WDTH = 4,
   parameter int DATA_WDTH = 32,
   parameter int RESP_WDTH = 1
);
   logic                 ar_valid;
   logic [ADDR_WDTH-1:0] ar_addr;
   logic                 ar_ready;
   logic                 r_valid;
   logic [DATA_WDTH-1:0] r_data;
   logic [RESP_WDTH-1:0] r_resp;
   logic                 r_ready;
   logic                 aw_valid;
   logic [ADDR_WDTH-1:0] aw_addr;
   logic                 aw_ready;
   logic                 w_valid;
   logic [DATA_WDTH-1:0] w_data;
   logic                 w_ready;
   logic                 b_valid;
   logic [RESP_WDTH-1:0] b_resp;
   logic                 b_ready;

   modport master (
      output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, b_ready,
      input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
   );

   modport slave (
      input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, b_ready,
      output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
   );
endinterface

// File: rtl/sort_mem.sv
// Register-file memory for the insertion sorter: fixed-latency read channel,
// independent AW/W capture with a single B response, host preload and debug port.
module sort_mem #(
   parameter int ADDR_WDTH = 4,
   parameter int DATA_WDTH = 32,
   parameter int RESP_WDTH = 1,
   parameter int ARR_SIZE  = 16,
   parameter int RD_LAT    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   sort_mem_if.slave            bus,
   input  logic                 init_we,
   input  logic [ADDR_WDTH-1:0] init_addr,
   input  logic [DATA_WDTH-1:0] init_data,
   input  logic [ADDR_WDTH-1:0] dbg_addr,
   output logic [DATA_WDTH-1:0] dbg_data
);
   localparam int DEPTH = 2 ** ADDR_WDTH;
   localparam int CNT_W = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;

   function automatic logic in_range(input logic [ADDR_WDTH-1:0] a);
      return {1'b0, a} < (ADDR_WDTH + 1)'(ARR_SIZE);
   endfunction

   // Full address-space view; words beyond ARR_SIZE read as zero.
   logic [DATA_WDTH-1:0] mem_view [DEPTH];

   // ---------------- write path ----------------
   logic                 aw_ready_reg, w_ready_reg, b_valid_reg;
   logic [RESP_WDTH-1:0] b_resp_reg;
   logic                 aw_held_reg, w_held_reg;
   logic [ADDR_WDTH-1:0] aw_addr_reg;
   logic [DATA_WDTH-1:0] w_data_reg;
   logic                 aw_fire, w_fire, b_fire, commit;
   logic [ADDR_WDTH-1:0] wr_addr;
   logic [DATA_WDTH-1:0] wr_data;
   logic                 aw_held_next, w_held_next, b_valid_next;

   assign aw_fire = bus.aw_valid & aw_ready_reg;
   assign w_fire  = bus.w_valid & w_ready_reg;
   assign b_fire  = b_valid_reg & bus.b_ready;

   always_comb begin
      commit       = (aw_held_reg | aw_fire) & (w_held_reg | w_fire);
      wr_addr      = aw_fire ? bus.aw_addr : aw_addr_reg;
      wr_data      = w_fire ? bus.w_data : w_data_reg;
      aw_held_next = (aw_held_reg | aw_fire) & ~commit;
      w_held_next  = (w_held_reg | w_fire) & ~commit;
      b_valid_next = commit | (b_valid_reg & ~b_fire);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held_reg  <= 1'b0;
         w_held_reg   <= 1'b0;
         aw_addr_reg  <= '0;
         w_data_reg   <= '0;
         aw_ready_reg <= 1'b0;
         w_ready_reg  <= 1'b0;
         b_valid_reg  <= 1'b0;
         b_resp_reg   <= '0;
      end else begin
         aw_held_reg  <= aw_held_next;
         w_held_reg   <= w_held_next;
         if (aw_fire) aw_addr_reg <= bus.aw_addr;
         if (w_fire)  w_data_reg  <= bus.w_data;
         aw_ready_reg <= ~aw_held_next & ~b_valid_next;
         w_ready_reg  <= ~w_held_next & ~b_valid_next;
         b_valid_reg  <= b_valid_next;
         if (commit) b_resp_reg <= RESP_WDTH'(~in_range(wr_addr));
      end
   end

   // ---------------- storage ----------------
   // Preload wins over a same-edge commit; the B response is unaffected.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_word
         if (gi < ARR_SIZE) begin : g_live
            logic [DATA_WDTH-1:0] word_reg;
            always_ff @(posedge clk) begin
               if (rst)
                  word_reg <= '0;
               else if (init_we && init_addr == ADDR_WDTH'(gi))
                  word_reg <= init_data;
               else if (commit && wr_addr == ADDR_WDTH'(gi))
                  word_reg <= wr_data;
            end
            assign mem_view[gi] = word_reg;
         end else begin : g_hole
            assign mem_view[gi] = '0;
         end
      end
   endgenerate

   assign dbg_data = mem_view[dbg_addr];

   // ---------------- read path ----------------
   rd_state_t            rd_state_reg, rd_state_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic                 ar_ready_reg, r_valid_reg;
   logic [DATA_WDTH-1:0] r_data_reg;
   logic [RESP_WDTH-1:0] r_resp_reg;
   logic                 ar_fire;

   assign ar_fire = bus.ar_valid & ar_ready_reg;

   always_comb begin
      rd_state_next = rd_state_reg;
      cnt_next      = cnt_reg;
      case (rd_state_reg)
         R_IDLE: begin
            if (ar_fire) begin
               rd_state_next = R_WAIT;
               cnt_next      = '0;
            end
         end
         R_WAIT: begin
            if (cnt_reg == CNT_W'(RD_LAT - 1))
               rd_state_next = R_RESP;
            else
               cnt_next = cnt_reg + CNT_W'(1);
         end
         R_RESP: begin
            if (bus.r_ready) rd_state_next = R_IDLE;
         end
         default: rd_state_next = R_IDLE;
      endcase
   end

   // Data is captured at the AR handshake so a same-edge write stays invisible.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_reg <= R_IDLE;
         cnt_reg      <= '0;
         ar_ready_reg <= 1'b0;
         r_valid_reg  <= 1'b0;
         r_data_reg   <= '0;
         r_resp_reg   <= '0;
      end else begin
         rd_state_reg <= rd_state_next;
         cnt_reg      <= cnt_next;
         ar_ready_reg <= (rd_state_next == R_IDLE);
         r_valid_reg  <= (rd_state_next == R_RESP);
         if (ar_fire) begin
            r_data_reg <= mem_view[bus.ar_addr];
            r_resp_reg <= RESP_WDTH'(~in_range(bus.ar_addr));
         end
      end
   end

   assign bus.ar_ready = ar_ready_reg;
   assign bus.r_valid  = r_valid_reg;
   assign bus.r_data   = r_data_reg;
   assign bus.r_resp   = r_resp_reg;
   assign bus.aw_ready = aw_ready_reg;
   assign bus.w_ready  = w_ready_reg;
   assign bus.b_valid  = b_valid_reg;
   assign bus.b_resp   = b_resp_reg;
endmodule

// File: doc/sort_mem.md
# sort_mem

- Word-addressed memory slave holding the array that the insertion-sort controller sorts in place.
- Serves the controller's handshake channels:
  - read: AR, R
  - write: AW, W, B
- Applies a fixed, parameterised read latency and flags out-of-range addresses with an error response.
- Provides a host-side preload port and a debug read port so a bench or top level can load the array and inspect it.

## Interface
- ADDR_WDTH, 4, word address width.
- DATA_WDTH, 32, word width.
- RESP_WDTH, 1, response width (0 = OKAY, 1 = ERROR).
- ARR_SIZE, 16, number of valid words (1 ≤ ARR_SIZE ≤ 2^ADDR_WDTH).
- RD_LAT, 2, cycles from AR handshake to r_valid (≥ 1).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ar_valid  in  1  read request valid.
- ar_addr  in  ADDR_WDTH  read address.
- ar_ready  out  1  read request accepted.
- r_valid  out  1  read data valid.
- r_data  out  DATA_WDTH  read data.
- r_resp  out  RESP_WDTH  read response.
- r_ready  in  1  master accepts read data.
- aw_valid / aw_addr / aw_ready  in/in/out  1/ADDR_WDTH/1  write address channel.
- w_valid / w_data / w_ready  in/in/out  1/DATA_WDTH/1  write data channel.
- b_valid  out  1  write response valid.
- b_resp  out  RESP_WDTH  write response.
- b_ready  in  1  master accepts response.
- init_we  in  1  host preload write enable.
- init_addr  in  ADDR_WDTH  host preload address.
- init_data  in  DATA_WDTH  host preload data.
- dbg_addr  in  ADDR_WDTH  debug read address.
- dbg_data  out  DATA_WDTH  combinational mem[dbg_addr]; 0 if out of range.

## Operation
- Storage: ARR_SIZE × DATA_WDTH registers. All words clear to 0 on rst.
- Handshake: a transfer occurs on any edge where valid && ready.
- Read FSM:
  - R_IDLE: ar_ready = 1.
  - On AR handshake, latch ar_addr and go to R_WAIT.
  - The latched data is the pre-edge memory value. A write committing on the same edge is not visible to this read.
  - R_WAIT: counter counts RD_LAT−1 cycles, then go to R_RESP.
  - R_RESP: r_valid = 1. r_data and r_resp stay stable until the R handshake, then return to R_IDLE.
  - Out-of-range address (addr ≥ ARR_SIZE): r_data = 0, r_resp = 1.
- Write path:
  - AW and W are captured independently, in either order or in the same cycle.
  - aw_ready = 1 while no address is held and b_valid = 0.
  - w_ready = 1 while no data is held and b_valid = 0.
  - On the edge where both address and data become held, the write commits: mem[addr] ← data if in range.
  - On that same edge, b_valid rises, b_resp = 0 (in range) or 1 (out of range, no write), and both holds clear.
  - b_valid holds until the B handshake.
- Preload: when init_we = 1, mem[init_addr] ← init_data on the edge (ignored if out of range).
  - Preload has priority over an AXI commit to the same address on the same edge. The commit is lost, but b_resp is still 0.
  - The master must not run transactions during preload (system contract; not checked).
- Read and write paths run concurrently and independently.

## Timing
- Reset values (edge where rst = 1):
  - ar_ready, aw_ready, w_ready = 0.
  - r_valid, b_valid = 0; r_data = 0; r_resp, b_resp = 0.
  - FSMs go to idle and all holds clear.
- All readies are registered and rise the first cycle after rst deasserts.
- Read latency: AR handshake at edge t → r_valid high from edge t+RD_LAT.
- After an R handshake at edge u:
  - r_valid is low after u.
  - ar_ready is high after u, so the next AR can be accepted at u+1.
- Write latency:
  - Last of AW/W handshake at edge t → b_valid high after t.
  - B handshake at edge u → aw_ready and w_ready high after u.
- r_valid and b_valid never drop without the matching ready (except on rst).
- rst mid-transaction aborts everything: pending R/B are dropped, readies go low for one cycle, memory clears.
- Worst-case throughput:
  - reads: one per RD_LAT+1 cycles with r_ready tied high.
  - writes: one per 2 cycles.

## Test plan
- Reset/preload/debug: assert rst, release, preload mem[k] = 100+k for k = 0..15, sweep dbg_addr → dbg_data = 100+k; readies low during the reset cycle, high one cycle later.
- Read latency with backpressure: RD_LAT = 2, read addr 5 at edge t → r_valid at t+2 with r_data = 105, r_resp = 0; hold r_ready low 3 cycles → r_data stable; next ar_ready high after the R handshake.
- Write ordering: W (data 0xDEAD) two cycles before AW (addr 3) → b_valid the cycle after the AW handshake, b_resp = 0; readback of addr 3 = 0xDEAD; repeat with AW/W in the same cycle.
- Out-of-range (ARR_SIZE = 12): write addr 13 → b_resp = 1, memory unchanged; read addr 14 → r_data = 0, r_resp = 1.
- Simultaneous events: AR to addr 7 on the same edge as a write commit to addr 7 (new value 9, old value 107) → r_data = 107, later read = 9; init_we to addr 2 with value 50 on the same edge as an AXI commit to addr 2 with value 60 → mem[2] = 50, b_resp = 0.
- Reset mid-operation: rst during R_WAIT and during a pending b_valid → no r_valid/b_valid afterwards, memory reads 0, next transaction completes normally.
